bolme_denetleyici: RTL

BOLME_DENETLEYICI -- requirements
Module: bolme_denetleyici

---
 rtl/bolme_denetleyici.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bolme_denetleyici.sv
// Divide-unit controller: screens special cases, sequences an external multi-cycle divider.
// Optional last-result cache is enabled by defining BOLME_ONBELLEK_EN.
module bolme_denetleyici #(
    parameter int unsigned VERI_GENISLIK  = 32,
    parameter int unsigned YAZMAC_GENISLIK = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       istek_gecerli_i,
    output logic                       istek_hazir_o,
    input  logic [1:0]                 islem_i,
    input  logic [VERI_GENISLIK-1:0]   bolunen_i,
    input  logic [VERI_GENISLIK-1:0]   bolen_i,
    input  logic [YAZMAC_GENISLIK-1:0] hedef_yazmac_i,
    input  logic                       temizle_i,
    output logic                       bb_basla_o,
    output logic [1:0]                 bb_islem_o,
    output logic [VERI_GENISLIK-1:0]   bb_bolunen_o,
    output logic [VERI_GENISLIK-1:0]   bb_bolen_o,
    input  logic [VERI_GENISLIK-1:0]   bb_sonuc_i,
    input  logic                       bb_bitti_i,
    output logic                       sonuc_gecerli_o,
    input  logic                       sonuc_hazir_i,
    output logic [VERI_GENISLIK-1:0]   sonuc_o,
    output logic [YAZMAC_GENISLIK-1:0] sonuc_yazmac_o
);

    localparam int unsigned W = VERI_GENISLIK;

    typedef enum logic [1:0] {BOS, HESAPLA, SONUC, IPTAL} durum_t;

    durum_t         durum, sonraki;
    logic           kabul;
    logic           bolen_sifir, tasma, isabet, ozel;
    logic [W-1:0]   ozel_sonuc;
    logic           tamamlandi;

`ifdef BOLME_ONBELLEK_EN
    logic           onb_gecerli;
    logic [1:0]     onb_islem;
    logic [W-1:0]   onb_bolunen, onb_bolen, onb_sonuc;
`endif

    assign kabul      = istek_gecerli_i & istek_hazir_o;
    assign tamamlandi = (durum == HESAPLA) & bb_bitti_i & ~temizle_i;

    // Requests answered without the divider: x/0, signed overflow, cache hit
    always_comb begin
        bolen_sifir = (bolen_i == '0);
        tasma       = islem_i[1] && (bolunen_i == {1'b1, {(W-1){1'b0}}}) && (bolen_i == '1);
`ifdef BOLME_ONBELLEK_EN
        isabet      = onb_gecerli && (onb_islem == islem_i) &&
                      (onb_bolunen == bolunen_i) && (onb_bolen == bolen_i);
`else
        isabet      = 1'b0;
`endif
        ozel        = bolen_sifir | tasma | isabet;
        ozel_sonuc  = '0;
        if (bolen_sifir)
            ozel_sonuc = islem_i[0] ? bolunen_i : '1;
        else if (tasma)
            ozel_sonuc = islem_i[0] ? '0 : bolunen_i;
`ifdef BOLME_ONBELLEK_EN
        else
            ozel_sonuc = onb_sonuc;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) durum <= BOS;
        else       durum <= sonraki;
    end

    // A divide in flight cannot be aborted, so a flush parks in IPTAL until it finishes
    always_comb begin
        sonraki = durum;
        case (durum)
            BOS:     if (kabul) sonraki = ozel ? SONUC : HESAPLA;
            HESAPLA: begin
                if (bb_bitti_i)     sonraki = temizle_i ? BOS : SONUC;
                else if (temizle_i) sonraki = IPTAL;
            end
            SONUC:   if (temizle_i || sonuc_hazir_i) sonraki = BOS;
            IPTAL:   if (bb_bitti_i) sonraki = BOS;
            default: sonraki = BOS;
        endcase
    end

    always_comb begin
        istek_hazir_o   = 1'b0;
        sonuc_gecerli_o = 1'b0;
        if (durum == BOS && !temizle_i && !rst_i) istek_hazir_o = 1'b1;
        if (durum == SONUC)                       sonuc_gecerli_o = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bb_basla_o     <= 1'b0;
            bb_islem_o     <= '0;
            bb_bolunen_o   <= '0;
            bb_bolen_o     <= '0;
            sonuc_o        <= '0;
            sonuc_yazmac_o <= '0;
        end else begin
            bb_basla_o <= 1'b0;
            if (kabul) begin
                bb_islem_o     <= islem_i;
                bb_bolunen_o   <= bolunen_i;
                bb_bolen_o     <= bolen_i;
                sonuc_yazmac_o <= hedef_yazmac_i;
                if (ozel) sonuc_o    <= ozel_sonuc;
                else      bb_basla_o <= 1'b1;
            end
            if (tamamlandi) sonuc_o <= bb_sonuc_i;
        end
    end

`ifdef BOLME_ONBELLEK_EN
    // Remembers only results that actually came back from the divider
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            onb_gecerli <= 1'b0;
            onb_islem   <= '0;
            onb_bolunen <= '0;
            onb_bolen   <= '0;
            onb_sonuc   <= '0;
        end else if (tamamlandi) begin
            onb_gecerli <= 1'b1;
            onb_islem   <= bb_islem_o;
            onb_bolunen <= bb_bolunen_o;
            onb_bolen   <= bb_bolen_o;
            onb_sonuc   <= bb_sonuc_i;
        end
    end
`endif

endmodule
